// File: rtl/mdu_sequencer.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply and restoring divide.
// Optional define MDU_DIVZERO_BYPASS_EN: divide-by-zero / signed-overflow ops finish in one cycle.
module mdu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [2:0]  op_in,
    input  logic        word_in,
    input  logic [63:0] src1_in,
    input  logic [63:0] src2_in,
    input  logic        flush,
    output logic        ready_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [63:0] result_out
);

    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [127:0]  acc_q, acc_d;
    logic [63:0]   mcand_q, mcand_d;
    logic [63:0]   src1x_q, src1x_d;
    logic [2:0]    op_q, op_d;
    logic          word_q, word_d;
    logic          neg_q, neg_d;
    logic          negr_q, negr_d;
    logic          dvz_q, dvz_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   result_q, result_d;

    function automatic logic [63:0] sext_w(input logic word, input logic [63:0] v);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Architected result for a zero divisor or most-negative / -1.
    function automatic logic [63:0] special_result(input logic [2:0] op, input logic dvz,
                                                   input logic [63:0] dividend);
        logic [63:0] r;
        if (op[1]) r = dvz ? dividend : 64'd0;
        else       r = dvz ? '1 : dividend;
        return r;
    endfunction

    function automatic logic [63:0] fix_result(input logic [2:0] op, input logic word,
                                               input logic neg, input logic negr,
                                               input logic dvz, input logic ovf,
                                               input logic [63:0] dividend,
                                               input logic [127:0] acc);
        logic [127:0] prod;
        logic [63:0]  q, rm, r;
        if (!op[2]) begin
            prod = word ? (acc >> 32) : acc;
            if (neg) prod = -prod;
            r = (op == 3'd0) ? prod[63:0] : prod[127:64];
        end else if (dvz || ovf) begin
            r = special_result(op, dvz, dividend);
        end else begin
            q  = neg  ? -acc[63:0]   : acc[63:0];
            rm = negr ? -acc[127:64] : acc[127:64];
            r  = op[1] ? rm : q;
        end
        return sext_w(word, r);
    endfunction

    // Operand conditioning for the op presented this cycle
    logic        a_signed, b_signed, zext_w, is_div, sa, sb, in_dvz, in_ovf;
    logic [63:0] a_x, b_x, mag_a, mag_b, min_neg;

    always_comb begin
        zext_w   = (op_in == 3'd5) || (op_in == 3'd7);
        a_signed = (op_in == 3'd0) || (op_in == 3'd1) || (op_in == 3'd2) ||
                   (op_in == 3'd4) || (op_in == 3'd6);
        b_signed = (op_in == 3'd0) || (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
        is_div   = op_in[2];
        if (word_in) begin
            a_x = zext_w ? {32'd0, src1_in[31:0]} : {{32{src1_in[31]}}, src1_in[31:0]};
            b_x = zext_w ? {32'd0, src2_in[31:0]} : {{32{src2_in[31]}}, src2_in[31:0]};
        end else begin
            a_x = src1_in;
            b_x = src2_in;
        end
        sa      = a_signed && a_x[63];
        sb      = b_signed && b_x[63];
        mag_a   = sa ? -a_x : a_x;
        mag_b   = sb ? -b_x : b_x;
        min_neg = word_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        in_dvz  = is_div && (b_x == 64'd0);
        in_ovf  = is_div && !op_in[0] && (a_x == min_neg) && (b_x == '1);
    end

    // One iteration step of each algorithm
    logic [64:0]  mul_sum, div_trial;
    logic [127:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, mcand_q} : 65'd0);
        mul_next  = {mul_sum, acc_q[63:1]};
        div_trial = acc_q[127:63] - {1'b0, mcand_q};
        div_next  = div_trial[64] ? {acc_q[126:0], 1'b0}
                                  : {div_trial[63:0], acc_q[62:0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        src1x_d  = src1x_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        dvz_d    = dvz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in && !flush) begin
                    op_d    = op_in;
                    word_d  = word_in;
                    src1x_d = a_x;
                    mcand_d = mag_b;
                    neg_d   = sa ^ sb;
                    negr_d  = sa;
                    dvz_d   = in_dvz;
                    ovf_d   = in_ovf;
                    cnt_d   = word_in ? 7'd32 : 7'd64;
                    // W divides pre-align the dividend so 32 steps consume its low word
                    if (is_div && word_in) acc_d = {64'd0, mag_a[31:0], 32'd0};
                    else                   acc_d = {64'd0, mag_a};
                    state_d = is_div ? ST_DIV : ST_MUL;
`ifdef MDU_DIVZERO_BYPASS_EN
                    if (in_dvz || in_ovf) begin
                        state_d  = ST_DONE;
                        result_d = sext_w(word_in, special_result(op_in, in_dvz, a_x));
                    end
`endif
                end
            end
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = ST_FIX;
            end
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = fix_result(op_q, word_q, neg_q, negr_q, dvz_q, ovf_q, src1x_q, acc_q);
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            src1x_q  <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            dvz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            src1x_q  <= src1x_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            dvz_q    <= dvz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign ready_out  = (state_q == ST_IDLE);
    assign busy_out   = (state_q != ST_IDLE);
    assign done_out   = (state_q == ST_DONE);
    assign result_out = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed table-driven bench for mdu_sequencer, plus flush and reset sequences.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [2:0]  op_in;
    logic        word_in;
    logic [63:0] src1_in, src2_in;
    logic        flush;
    logic        ready_out, busy_out, done_out;
    logic [63:0] result_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .op_in(op_in), .word_in(word_in),
        .src1_in(src1_in), .src2_in(src2_in), .flush(flush), .ready_out(ready_out),
        .busy_out(busy_out), .done_out(done_out), .result_out(result_out)
    );

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        special;   // divisor zero or signed overflow
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input logic special);
        vec_t v;
        v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp; v.special = special;
        vq.push_back(v);
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef MDU_DIVZERO_BYPASS_EN
        if (v.special) return 1;
`endif
        return v.word ? 34 : 66;
    endfunction

    // Accept on one edge, then count cycles until done_out; valid stays high while busy.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit busy_ok;
        @(negedge clk);
        valid_in = 1'b1; op_in = v.op; word_in = v.word; src1_in = v.a; src2_in = v.b;
        @(posedge clk); #1;
        lat = 1;
        busy_ok = 1'b1;
        while (!done_out && lat < 200) begin
            if (!busy_out || ready_out) busy_ok = 1'b0;
            if (lat == 3) begin
                op_in = ~v.op; word_in = ~v.word; src1_in = ~v.a; src2_in = ~v.b;
            end
            @(posedge clk); #1;
            lat++;
        end
        valid_in = 1'b0;
        chk({tag, " latency"}, done_out ? 64'(lat) : 64'd999, 64'(exp_lat(v)));
        chk({tag, " result"}, result_out, v.exp);
        chk({tag, " busy_before_done"}, 64'(busy_ok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy_out), 64'd1);
        @(posedge clk); #1;
        chk({tag, " done_one_pulse"}, {62'd0, done_out, ready_out}, 64'd1);
        chk({tag, " result_held"}, result_out, v.exp);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done_out) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [63:0] last;

        add(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        add(3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        add(3'd1, 1'b0, '1, '1, 64'd0, 1'b0);
        add(3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        add(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1);
        add(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1);
        add(3'd5, 1'b0, 64'd100, 64'd0, '1, 1'b1);
        add(3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1'b1);
        add(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        add(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        add(3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        add(3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hABCD_0000_0000_0002, 64'h0000_0000_7FFF_FFFF, 1'b0);
        add(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        add(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1);
        add(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
        add(3'd0, 1'b0, 64'h1_2345_6789, 64'h1000, 64'h1234_5678_9000, 1'b0);
        add(3'd5, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, '1, 1'b1);
        add(3'd7, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1);
        add(3'd5, 1'b0, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0);
        add(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1'b0);

        reset = 1'b0; valid_in = 1'b0; op_in = '0; word_in = 1'b0;
        src1_in = '0; src2_in = '0; flush = 1'b0;
        #1;
        chk("reset ready", 64'(ready_out), 64'd1);
        chk("reset busy", 64'(busy_out), 64'd0);
        chk("reset done", 64'(done_out), 64'd0);
        chk("reset result", result_out, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("vec%0d", i));
        last = vq[vq.size() - 1].exp;

        // Flush a DIV at cycle 10
        @(negedge clk);
        valid_in = 1'b1; op_in = 3'd4; word_in = 1'b0; src1_in = 64'd1000; src2_in = 64'd7;
        @(posedge clk); #1;
        for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
        chk("flush busy_c10", 64'(busy_out), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        chk("flush ready_c11", 64'(ready_out), 64'd1);
        chk("flush busy_c11", 64'(busy_out), 64'd0);
        chk("flush result_kept", result_out, last);
        watch_no_done("flush no_done", 80);

        // valid with flush while idle is not accepted
        @(negedge clk);
        valid_in = 1'b1; flush = 1'b1; op_in = 3'd0; src1_in = 64'd3; src2_in = 64'd5;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        chk("flush_idle not_accepted", 64'(ready_out), 64'd1);
        watch_no_done("flush_idle no_done", 70);
        chk("flush_idle result_kept", result_out, last);

        v.op = 3'd0; v.word = 1'b0; v.a = 64'd9; v.b = 64'd11; v.exp = 64'd99; v.special = 1'b0;
        run_vec(v, "after_flush");

        // Asynchronous reset during a REM at cycle 20
        @(negedge clk);
        valid_in = 1'b1; op_in = 3'd6; word_in = 1'b0;
        src1_in = 64'hFFFF_FFFF_FFFF_FF9C; src2_in = 64'd7;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int c = 1; c < 20; c++) begin @(posedge clk); #1; end
        chk("rst busy_c20", 64'(busy_out), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst result", result_out, 64'd0);
        chk("rst ready", 64'(ready_out), 64'd1);
        chk("rst busy", 64'(busy_out), 64'd0);
        chk("rst done", 64'(done_out), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        watch_no_done("rst no_done", 80);

        v.op = 3'd6; v.word = 1'b0; v.a = 64'hFFFF_FFFF_FFFF_FF9C; v.b = 64'd7;
        v.exp = 64'hFFFF_FFFF_FFFF_FFFE; v.special = 1'b0;
        run_vec(v, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
